// File: rtl/uart_baud_gen.sv
//------------------------------------------------------------------------------
// uart_baud_gen : fractional UART baud generator (16x oversample and bit ticks)
// Optional fractional divisor enabled by defining BAUD_FRAC_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_baud_gen #(
  parameter logic [15:0] DEF_INT  = 16'd162,
  parameter logic [3:0]  DEF_FRAC = 4'd12
) (
  input  logic        clk_p,
  input  logic        reset_p,
  input  logic        en,
  input  logic [15:0] div_int,
  input  logic [3:0]  div_frac,
  input  logic        div_load,
  output logic        div_ack,
  output logic        tick16,
  output logic        tick_bit,
  output logic [3:0]  tick_phase
);

  // A divisor is carried as one word: {frac, int} or just int.
`ifdef BAUD_FRAC_EN
  localparam int DW = 20;
  localparam logic [DW-1:0] DEF_WORD = {DEF_FRAC, DEF_INT};
  logic [DW-1:0] load_word;
  assign load_word = {div_frac, div_int};
`else
  localparam int DW = 16;
  localparam logic [DW-1:0] DEF_WORD = DEF_INT;
  logic [DW-1:0] load_word;
  logic          unused_frac;
  assign load_word   = div_int;
  assign unused_frac = ^{div_frac, DEF_FRAC};
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [16:0]   cnt_q, cnt_d;
  logic [16:0]   len_q, len_d;
  logic [DW-1:0] act_q, act_d;
  logic [DW-1:0] pend_word_q, pend_word_d;
  logic          pend_q, pend_d;
  logic          tick16_q, tick16_d;
  logic          tick_bit_q, tick_bit_d;
  logic [3:0]    phase_q, phase_d;
  logic          ack_q, ack_d;
  logic          start;
  logic [15:0]   int_eff;
`ifdef BAUD_FRAC_EN
  logic [3:0]    acc_q, acc_d;
  logic [3:0]    acc_base;
  logic [4:0]    frac_sum;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    act_d       = act_q;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;
    tick16_d    = 1'b0;
    tick_bit_d  = 1'b0;
    phase_d     = phase_q;
    ack_d       = 1'b0;
    start       = 1'b0;
`ifdef BAUD_FRAC_EN
    acc_d       = acc_q;
    acc_base    = (state_q == RUN) ? acc_q : 4'd0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        phase_d = 4'd0;
`ifdef BAUD_FRAC_EN
        acc_d   = 4'd0;
`endif
        if (div_load) begin
          act_d = load_word;
          ack_d = 1'b1;
        end
        if (en) begin
          state_d = RUN;
          cnt_d   = 17'd1;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          // Leaving RUN wins over any coincident boundary.
          state_d = IDLE;
          cnt_d   = '0;
          phase_d = 4'd0;
          pend_d  = 1'b0;
`ifdef BAUD_FRAC_EN
          acc_d   = 4'd0;
`endif
          if (div_load) begin
            act_d = load_word;
            ack_d = 1'b1;
          end else if (pend_q) begin
            act_d = pend_word_q;
            ack_d = 1'b1;
          end
        end else begin
          if (cnt_q == len_q) begin
            tick16_d   = 1'b1;
            tick_bit_d = (phase_q == 4'd15);
            phase_d    = phase_q + 4'd1;
            cnt_d      = 17'd1;
            start      = 1'b1;
            if (pend_q) begin
              act_d  = pend_word_q;
              ack_d  = 1'b1;
              pend_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 17'd1;
          end
          // A load on a boundary edge waits for the following boundary.
          if (div_load) begin
            pend_d      = 1'b1;
            pend_word_d = load_word;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    int_eff = (act_d[15:0] < 16'd2) ? 16'd2 : act_d[15:0];
`ifdef BAUD_FRAC_EN
    frac_sum = {1'b0, acc_base} + {1'b0, act_d[19:16]};
    if (start) begin
      acc_d = frac_sum[3:0];
      len_d = {1'b0, int_eff} + {16'd0, frac_sum[4]};
    end
`else
    if (start) begin
      len_d = {1'b0, int_eff};
    end
`endif
  end

  always_ff @(posedge clk_p) begin
    if (reset_p) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      act_q       <= DEF_WORD;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      tick16_q    <= 1'b0;
      tick_bit_q  <= 1'b0;
      phase_q     <= 4'd0;
      ack_q       <= 1'b0;
`ifdef BAUD_FRAC_EN
      acc_q       <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
      tick16_q    <= tick16_d;
      tick_bit_q  <= tick_bit_d;
      phase_q     <= phase_d;
      ack_q       <= ack_d;
`ifdef BAUD_FRAC_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign div_ack    = ack_q;
  assign tick16     = tick16_q;
  assign tick_bit   = tick_bit_q;
  assign tick_phase = phase_q;

endmodule

`default_nettype wire
